echo_meas_multi: RTL and testbench
==================================

ECHO_MEAS_MULTI -- requirements
Module: echo_meas_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent echo channels.
REQ-002 Parameter CNT_W, default 24: width of each per-channel counter and result.
REQ-003 Parameter WAIT_MAX, default 1000000: maximum cycles in ARMED while waiting for a rising echo edge.
REQ-004 Parameter HIGH_MAX, default 3800000: maximum counted echo-high cycles before an overrange error.
REQ-005 Parameter SYNC_STG, default 2: number of synchroniser flops on each echo input, at least 2.
REQ-006 Port clk, in, 1: the single clock; all logic is on its rising edge.
REQ-007 Port rst_n, in, 1: reset, asynchronous and active-low.
REQ-008 Port echo, in, N_CH: raw asynchronous echo level, one bit per channel.
REQ-009 Port start, in, N_CH: per-channel arm request, sampled high for one cycle.
REQ-010 Port busy, out, N_CH: channel is in ARMED or HIGH.
REQ-011 Port done, out, N_CH: one-cycle pulse marking the end of a measurement, whether it succeeded or failed.
REQ-012 Port meas, out, N_CH*CNT_W: echo-high width in clk cycles, channel k in bits [k*CNT_W +: CNT_W], held until the next done.
REQ-013 Port err, out, N_CH*2: error code per channel (00 ok, 01 no echo, 10 overrange), held until the next done.

Function
REQ-014 Each echo bit shall pass through SYNC_STG flops to give echo_s; a rising edge is echo_s=1 while the previous echo_s=0, and a falling edge is the reverse.
REQ-015 Each channel shall run a four-state FSM: IDLE, ARMED, HIGH, DONE.
REQ-016 In IDLE, start=1 shall move the channel to ARMED and clear its counter the next cycle.
REQ-017 start shall be ignored while the channel is in ARMED, HIGH or DONE, and shall have no effect on any other channel.
REQ-018 In ARMED, the counter shall increment every cycle.
REQ-019 In ARMED, a rising edge shall move the channel to HIGH with the counter set to 1.
REQ-020 If the counter reaches WAIT_MAX in ARMED with no rising edge, the channel shall go to DONE with meas=0 and err=01.
REQ-021 An echo already high when the channel is armed shall not count; only a new rising edge starts a measurement.
REQ-022 In HIGH, while echo_s=1, the counter shall increment every cycle.
REQ-023 In HIGH, a falling edge shall latch meas=counter and err=00, then move to DONE.
REQ-024 In HIGH, when the counter equals HIGH_MAX with echo_s still 1, the channel shall go to DONE with meas=HIGH_MAX and err=10.
REQ-025 If a falling edge and counter==HIGH_MAX occur in the same cycle, the falling edge shall win: err=00 and meas=HIGH_MAX.
REQ-026 DONE shall last exactly one cycle, with done=1 and busy=0, and then return to IDLE; a start in that cycle shall be ignored.
REQ-027 For a clean pulse of W cycles, meas shall equal W; done shall assert SYNC_STG+1 cycles after the raw falling edge.
REQ-028 The counter shall saturate and never wrap.
REQ-029 Elaboration shall fail unless 2^CNT_W > max(WAIT_MAX, HIGH_MAX) and SYNC_STG >= 2.

Reset
REQ-030 While rst_n=0, every channel shall be in IDLE and every counter and synchroniser flop shall be 0.
REQ-031 While rst_n=0, outputs shall be busy=0, done=0, meas=0 and err=00.
REQ-032 Reset asserted mid-measurement shall abort the measurement with no done pulse.
REQ-033 After reset is released, a channel shall need a new start before it measures again.

Structure
REQ-034 Package echo_meas_pkg shall hold the FSM state enum (IDLE, ARMED, HIGH, DONE) and the err code constants ERR_OK, ERR_NOECHO and ERR_OVR.
REQ-035 One sub-module, echo_meas_ch, shall implement a single channel (synchroniser, FSM, counter, result registers).
REQ-036 The top level shall instantiate echo_meas_ch N_CH times with a generate loop and pack the outputs.

Verification
REQ-037 Reset, then start ch0, then a raw echo high for 500 cycles -> one done pulse on ch0, meas[0]=500, err[0]=00, and ch1-3 stay idle.
REQ-038 With WAIT_MAX=100, start ch1 and apply no echo -> done on ch1 exactly 100 cycles after entering ARMED, with meas=0 and err=01.
REQ-039 With HIGH_MAX=50, start ch2 and hold echo high for 200 cycles -> done with meas=50 and err=10; the later falling edge causes no second done.
REQ-040 Hold echo high before start, release it, then apply a 30-cycle pulse -> meas=30; the pre-existing high level is not counted.
REQ-041 Start all channels with pulse widths 10, 20, 30 and 40, then assert rst_n=0 during ch3's pulse -> ch0-2 report correctly, ch3 gives no done, and all outputs read 0.
REQ-042 Pulse start again while ch0 is busy -> no effect, and meas reflects only the first measurement.

Source files
------------

// File: rtl/echo_meas_pkg.sv
// Shared types and constants for the multi-channel echo pulse-width meter.
package echo_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    DONE  = 2'd3
  } ch_state_t;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_NOECHO = 2'b01;
  localparam logic [1:0] ERR_OVR    = 2'b10;

  function automatic longint max_of(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/echo_meas_ch.sv
// One echo channel: input synchroniser, measurement FSM, saturating counter
// and result registers that hold until the next measurement completes.
//
// state | meaning
// IDLE  | waiting for start
// ARMED | counting wait cycles until a new rising echo edge or timeout
// HIGH  | counting echo-high cycles until falling edge or overrange
// DONE  | one-cycle done pulse, results updated, back to IDLE
module echo_meas_ch
  import echo_meas_pkg::*;
#(
  parameter int CNT_W    = 24,
  parameter int WAIT_MAX = 1000000,
  parameter int HIGH_MAX = 3800000,
  parameter int SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             echo,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] meas,
  output logic [1:0]       err
);

  localparam longint CNT_RANGE = longint'(1) << CNT_W;

  if (SYNC_STG < 2) begin : g_bad_sync
    $error("echo_meas_ch: SYNC_STG must be at least 2");
  end
  if (CNT_RANGE <= max_of(longint'(WAIT_MAX), longint'(HIGH_MAX))) begin : g_bad_width
    $error("echo_meas_ch: CNT_W too narrow for WAIT_MAX/HIGH_MAX");
  end

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] HIGH_LIM = CNT_W'(HIGH_MAX);

  ch_state_t          state_q, state_d;
  logic [SYNC_STG-1:0] sync_q;
  logic               echo_s, echo_d;
  logic               rise, fall;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]   meas_q, meas_d;
  logic [1:0]         err_q, err_d;

  assign echo_s  = sync_q[SYNC_STG-1];
  assign rise    = echo_s & ~echo_d;
  assign fall    = ~echo_s & echo_d;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      echo_d  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      meas_q  <= '0;
      err_q   <= ERR_OK;
    end else begin
      sync_q  <= {sync_q[SYNC_STG-2:0], echo};
      echo_d  <= echo_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      meas_q  <= meas_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    meas_d  = meas_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        // Only a fresh edge starts a measurement; a level already high is ignored.
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(1);
        end else if (cnt_inc >= WAIT_LIM) begin
          state_d = DONE;
          cnt_d   = cnt_inc;
          meas_d  = '0;
          err_d   = ERR_NOECHO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = DONE;
          meas_d  = cnt_q;
          err_d   = ERR_OK;
        end else if (cnt_q >= HIGH_LIM) begin
          state_d = DONE;
          meas_d  = HIGH_LIM;
          err_d   = ERR_OVR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == ARMED) || (state_q == HIGH);
  assign done = (state_q == DONE);
  assign meas = meas_q;
  assign err  = err_q;

endmodule

// File: rtl/echo_meas_multi.sv
// N_CH independent echo pulse-width meters with packed result buses.
module echo_meas_multi
  import echo_meas_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 24,
  parameter int WAIT_MAX = 1000000,
  parameter int HIGH_MAX = 3800000,
  parameter int SYNC_STG = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       echo,
  input  logic [N_CH-1:0]       start,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic [N_CH*CNT_W-1:0] meas,
  output logic [N_CH*2-1:0]     err
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    echo_meas_ch #(
      .CNT_W    (CNT_W),
      .WAIT_MAX (WAIT_MAX),
      .HIGH_MAX (HIGH_MAX),
      .SYNC_STG (SYNC_STG)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .echo  (echo[k]),
      .start (start[k]),
      .busy  (busy[k]),
      .done  (done[k]),
      .meas  (meas[k*CNT_W +: CNT_W]),
      .err   (err[k*2 +: 2])
    );
  end

endmodule

// File: tb/tb_echo_meas_multi.sv
// Scoreboard bench: two instances (long and short limits) driven by directed pulses.
module tb_echo_meas_multi;

  localparam int NCH = 4;
  localparam int CW  = 24;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    echo_a, start_a, busy_a, done_a;
  logic [NCH*CW-1:0] meas_a;
  logic [NCH*2-1:0]  err_a;
  logic [NCH-1:0]    echo_b, start_b, busy_b, done_b;
  logic [NCH*CW-1:0] meas_b;
  logic [NCH*2-1:0]  err_b;

  echo_meas_multi #(.N_CH(NCH), .CNT_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .echo(echo_a), .start(start_a),
    .busy(busy_a), .done(done_a), .meas(meas_a), .err(err_a)
  );

  echo_meas_multi #(.N_CH(NCH), .CNT_W(CW), .WAIT_MAX(100), .HIGH_MAX(50)) dut_b (
    .clk(clk), .rst_n(rst_n), .echo(echo_b), .start(start_b),
    .busy(busy_b), .done(done_b), .meas(meas_b), .err(err_b)
  );

  typedef struct {
    int id;
    int meas;
    int err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt[2*NCH];
  int   last_cyc[2*NCH];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match a queued expectation for that channel.
  always @(negedge clk) begin
    for (int i = 0; i < 2*NCH; i++) begin
      logic d;
      int   m, e, idx, c;
      c = i % NCH;
      if (i < NCH) begin
        d = done_a[c]; m = int'(meas_a[c*CW +: CW]); e = int'(err_a[c*2 +: 2]);
      end else begin
        d = done_b[c]; m = int'(meas_b[c*CW +: CW]); e = int'(err_b[c*2 +: 2]);
      end
      if (d) begin
        done_cnt[i]++;
        last_cyc[i] = cyc;
        idx = -1;
        foreach (sb[j]) if (idx < 0 && sb[j].id == i) idx = j;
        if (idx < 0) begin
          check($sformatf("unexpected_done_id%0d", i), 1, 0);
        end else begin
          check($sformatf("meas_id%0d", i), m, sb[idx].meas);
          check($sformatf("err_id%0d", i), e, sb[idx].err);
          sb.delete(idx);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input int m, input int e);
    exp_t x;
    x.id = id; x.meas = m; x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_done(input int id, input int prev, input int limit, input string nm);
    int n = 0;
    while (done_cnt[id] == prev && n < limit) begin
      tick(1);
      n++;
    end
    check({nm, "_done_seen"}, longint'(done_cnt[id] != prev), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, prev;
    for (int i = 0; i < 2*NCH; i++) begin
      done_cnt[i] = 0;
      last_cyc[i] = 0;
    end
    rst_n = 1'b0;
    echo_a = '0; start_a = '0; echo_b = '0; start_b = '0;
    tick(3);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_meas_a", longint'(meas_a), 0);
    check("rst_err_b", err_b, 0);
    rst_n = 1'b1;
    tick(3);

    // Clean 500-cycle pulse on ch0; others stay idle.
    push(0, 500, 0);
    prev = done_cnt[0];
    start_a[0] = 1'b1; tick(1); start_a[0] = 1'b0;
    tick(5);
    check("ch0_busy_armed", busy_a[0], 1);
    echo_a[0] = 1'b1; tick(250);
    check("ch123_idle", busy_a[3:1], 0);
    tick(250);
    echo_a[0] = 1'b0; p = cyc;
    wait_done(0, prev, 20, "ch0_500");
    check("ch0_done_latency", last_cyc[0] - p, 3);
    check("ch0_busy_after", busy_a[0], 0);

    // No echo: timeout after exactly 100 armed cycles.
    prev = done_cnt[NCH+1];
    push(NCH+1, 0, 1);
    start_b[1] = 1'b1; p = cyc; tick(1); start_b[1] = 1'b0;
    wait_done(NCH+1, prev, 200, "b_ch1_noecho");
    check("b_ch1_timeout_cycles", last_cyc[NCH+1] - p, 101);

    // Overrange at 50, later falling edge gives no second done.
    prev = done_cnt[NCH+2];
    push(NCH+2, 50, 2);
    start_b[2] = 1'b1; tick(1); start_b[2] = 1'b0;
    tick(3);
    echo_b[2] = 1'b1; tick(200); echo_b[2] = 1'b0;
    tick(10);
    check("b_ch2_done_count", done_cnt[NCH+2] - prev, 1);

    // Pre-existing high level is not measured.
    prev = done_cnt[1];
    push(1, 30, 0);
    echo_a[1] = 1'b1; tick(5);
    start_a[1] = 1'b1; tick(1); start_a[1] = 1'b0;
    tick(10);
    echo_a[1] = 1'b0; tick(10);
    check("ch1_still_armed", busy_a[1], 1);
    check("ch1_no_early_done", done_cnt[1] - prev, 0);
    echo_a[1] = 1'b1; tick(30); echo_a[1] = 1'b0;
    wait_done(1, prev, 20, "ch1_preheld");

    // Restart while busy is ignored; start during DONE is ignored too.
    prev = done_cnt[0];
    push(0, 25, 0);
    start_a[0] = 1'b1; tick(1); start_a[0] = 1'b0;
    tick(3);
    echo_a[0] = 1'b1; tick(10);
    start_a[0] = 1'b1; tick(1); start_a[0] = 1'b0;
    tick(14); echo_a[0] = 1'b0;
    p = 0;
    while (!done_a[0] && p < 20) begin
      @(negedge clk);
      p++;
    end
    check("ch0_restart_done_seen", done_a[0], 1);
    start_a[0] = 1'b1;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    tick(3);
    check("ch0_start_in_done_ignored", busy_a[0], 0);
    check("ch0_restart_done_count", done_cnt[0] - prev, 1);
    check("ch0_meas_held", longint'(meas_a[0 +: CW]), 25);

    // All channels, reset during ch3's pulse.
    push(0, 10, 0); push(1, 20, 0); push(2, 30, 0);
    prev = done_cnt[3];
    start_a = 4'hF; tick(1); start_a = '0;
    tick(3);
    echo_a = 4'hF;
    tick(10); echo_a[0] = 1'b0;
    tick(10); echo_a[1] = 1'b0;
    tick(10); echo_a[2] = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick(3);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_done", done_a, 0);
    check("rst_mid_meas", longint'(meas_a), 0);
    check("rst_mid_err", err_a, 0);
    echo_a = '0;
    rst_n = 1'b1;
    tick(10);
    check("ch3_no_done", done_cnt[3] - prev, 0);
    echo_a[3] = 1'b1; tick(10); echo_a[3] = 1'b0; tick(10);
    check("ch3_needs_start", busy_a[3], 0);
    check("ch3_no_done_after_rst", done_cnt[3] - prev, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
